mem_arbiter: RTL and testbench

Two-port-to-one memory arbiter that shares the single slow main-memory port between the instruction cache (read-only) and the data cache (read/write). It sits between the cache pair and the off-chip memory model used by the CPU testbenches. It serialises block transfers and returns each completion only to the requester that owns it. A streak counter keeps the I-cache from being starved under D-cache pressure.

---
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one slow main-memory port between the instruction cache (read-only)
//   and the data cache (read/write). Block transfers are serialised: a single
//   owner holds the memory port from its grant until mem_ready, and only that
//   owner sees its ready pulse and read data. A D-grant streak counter hands
//   the port to a waiting I-cache after MAX_D_STREAK consecutive D grants.
//
// Ports
//   clk, rst                    clock; asynchronous active-low reset
//   d_read, d_write, d_addr,
//   d_wdata, d_rdata, d_ready   D-cache request/response
//   i_read, i_addr, i_rdata,
//   i_ready                     I-cache request/response
//   mem_read, mem_write,
//   mem_addr, mem_wdata         registered memory command (held until mem_ready)
//   mem_rdata, mem_ready        memory response
//   grant_d, grant_i            current owner, mutually exclusive
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W       = 28,
  parameter int DATA_W       = 128,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              grant_d,
  output logic              grant_i
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2
  } state_e;

  state_e              state_q,     state_d;
  logic                mem_read_q,  mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STREAK_W-1:0] streak_q,    streak_d;

  logic d_req;
  logic d_wins;

  assign d_req = d_read | d_write;
  // D wins any contest until it has taken MAX_D_STREAK grants in a row
  // while the I-cache was waiting.
  assign d_wins = d_req && !(i_read && (streak_q == STREAK_MAX));

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    streak_d    = streak_q;

    unique case (state_q)
      IDLE: begin
        if (d_wins) begin
          state_d     = BUSY_D;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          // Read and write together is resolved as a write.
          mem_write_d = d_write;
          mem_read_d  = ~d_write;
          // A contested D win implies streak_q < MAX, so +1 cannot overflow.
          streak_d    = i_read ? streak_q + STREAK_W'(1) : '0;
        end else if (i_read) begin
          state_d     = BUSY_I;
          mem_addr_d  = i_addr;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          streak_d    = '0;
        end
      end
      BUSY_D, BUSY_I: begin
        // Requester inputs are ignored here; the latched command stays put.
        if (mem_ready) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      // NOTE: the wide address/data holding registers are reset too, because
      // their reset value is visible on mem_addr/mem_wdata.
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      streak_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      streak_q    <= streak_d;
    end
  end

  assign grant_d   = (state_q == BUSY_D);
  assign grant_i   = (state_q == BUSY_I);
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Completion is steered combinationally to the owner only; a mem_ready
  // arriving in IDLE therefore produces nothing.
  assign d_ready = grant_d & mem_ready;
  assign i_ready = grant_i & mem_ready;
  assign d_rdata = d_ready ? mem_rdata : '0;
  assign i_rdata = i_ready ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter: a table of single-transaction
//   vectors, directed multi-cycle sequences (latency, contention, starvation,
//   held command, spurious ready, reset abort) and a randomized run checked
//   against a transaction-level reference model with a memory array.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW  = 28;
  localparam int DW  = 128;
  localparam int MAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          d_read, d_write, i_read, mem_ready;
  logic [AW-1:0] d_addr, i_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [DW-1:0] d_rdata, i_rdata, mem_wdata;
  logic          d_ready, i_ready, mem_read, mem_write, grant_d, grant_i;
  logic [AW-1:0] mem_addr;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAX)) dut (
    .clk(clk), .rst(rst),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant_d(grant_d), .grant_i(grant_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    d_read = 0; d_write = 0; i_read = 0; mem_ready = 0;
    d_addr = '0; i_addr = '0; d_wdata = '0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 0;
    tick();
    tick();
    rst = 1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_read"},  mem_read,  0);
    check({tag, "_mem_write"}, mem_write, 0);
    check({tag, "_mem_addr"},  mem_addr,  0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_grants"},    {grant_d, grant_i}, 0);
    check({tag, "_readys"},    {d_ready, i_ready}, 0);
  endtask

  typedef struct {
    logic          dr, dw, ir;
    logic [AW-1:0] da, ia;
    logic [DW-1:0] wd;
    logic          eg_d, e_rd, e_wr;
    logic [AW-1:0] e_addr;
  } vec_t;

  vec_t vecs[6];

  // Reference-model state for the randomized run.
  int                owner;      // 0 none, 1 D, 2 I
  int                streak_m;
  int                lat;
  logic              exp_wr;
  logic [AW-1:0]     exp_addr;
  logic [DW-1:0]     exp_wd, rd_val;
  logic [DW-1:0]     mem_m [logic [AW-1:0]];
  logic              p_dr, p_dw, p_ir, p_ready, p_dready, p_iready;
  logic [AW-1:0]     p_da, p_ia;
  logic [DW-1:0]     p_wd;

  initial begin
    logic [DW-1:0] pat_a5;
    int            cnt, pulses_d, pulses_i;
    string         seq_exp, seq_got;

    pat_a5 = {16{8'hA5}};
    rst = 0;
    clear_inputs();
    #2;
    check_all_zero("reset_state");
    tick();
    rst = 1;
    tick();

    // ---------------- table-driven single transactions ----------------
    vecs[0] = '{1,0,0, 28'h1, 28'h0, '0,          1,1,0, 28'h1};
    vecs[1] = '{0,1,0, 28'h2, 28'h0, 128'hBEEF,   1,0,1, 28'h2};
    vecs[2] = '{0,0,1, 28'h0, 28'h3, '0,          0,1,0, 28'h3};
    vecs[3] = '{1,0,1, 28'h4, 28'h5, '0,          1,1,0, 28'h4};
    vecs[4] = '{0,1,1, 28'h6, 28'h7, 128'hC0FFEE, 1,0,1, 28'h6};
    vecs[5] = '{1,1,1, 28'h8, 28'h9, 128'hF00D,   1,0,1, 28'h8};
    for (int v = 0; v < 6; v++) begin
      d_read = vecs[v].dr; d_write = vecs[v].dw; i_read = vecs[v].ir;
      d_addr = vecs[v].da; i_addr = vecs[v].ia; d_wdata = vecs[v].wd;
      tick();
      check($sformatf("vec%0d_grant_d", v),   grant_d,   vecs[v].eg_d);
      check($sformatf("vec%0d_grant_i", v),   grant_i,   !vecs[v].eg_d);
      check($sformatf("vec%0d_mem_read", v),  mem_read,  vecs[v].e_rd);
      check($sformatf("vec%0d_mem_write", v), mem_write, vecs[v].e_wr);
      check($sformatf("vec%0d_mem_addr", v),  mem_addr,  vecs[v].e_addr);
      if (vecs[v].e_wr) check($sformatf("vec%0d_mem_wdata", v), mem_wdata, vecs[v].wd);
      mem_ready = 1; mem_rdata = 128'h5A00 + v;
      #1;
      check($sformatf("vec%0d_d_ready", v), d_ready, vecs[v].eg_d);
      check($sformatf("vec%0d_i_ready", v), i_ready, !vecs[v].eg_d);
      tick();
      clear_inputs();
      check($sformatf("vec%0d_idle", v), {mem_read, mem_write, grant_d, grant_i}, 0);
      tick();
    end

    // ---------------- single D read, 8-cycle memory latency ----------------
    d_read = 1; d_addr = 28'h0000010;
    cnt = 0; pulses_d = 0; pulses_i = 0;
    tick();
    for (int c = 0; c < 12 && (c == 0 || mem_read); c++) begin
      if (mem_read) cnt++;
      mem_ready = (c == 8); mem_rdata = (c == 8) ? pat_a5 : '0;
      #1;
      if (d_ready) begin
        pulses_d++;
        check("dread_rdata", d_rdata, pat_a5);
      end
      if (i_ready) pulses_i++;
      tick();
      mem_ready = 0;
      if (c == 8) d_read = 0;
    end
    check("dread_strobe_cycles", cnt, 9);
    check("dread_d_pulses", pulses_d, 1);
    check("dread_i_pulses", pulses_i, 0);
    check("dread_strobe_low", mem_read, 0);
    tick();

    // ---------------- simultaneous D write and I read ----------------
    d_write = 1; d_addr = 28'h20; d_wdata = 128'h1234;
    i_read = 1; i_addr = 28'h40;
    tick();
    check("simul_grant_d", {grant_d, grant_i}, 2'b10);
    check("simul_d_cmd", {mem_read, mem_write}, 2'b01);
    check("simul_d_addr", mem_addr, 28'h20);
    check("simul_d_wdata", mem_wdata, 128'h1234);
    mem_ready = 1;
    #1;
    check("simul_d_ready", {d_ready, i_ready}, 2'b10);
    tick();
    mem_ready = 0; d_write = 0;
    check("simul_gap", {mem_read, mem_write, grant_d, grant_i}, 0);
    tick();
    check("simul_grant_i", {grant_d, grant_i}, 2'b01);
    check("simul_i_cmd", {mem_read, mem_write}, 2'b10);
    check("simul_i_addr", mem_addr, 28'h40);
    mem_ready = 1; mem_rdata = 128'h4040;
    #1;
    check("simul_i_ready", {d_ready, i_ready}, 2'b01);
    check("simul_i_rdata", i_rdata, 128'h4040);
    check("simul_d_rdata_zero", d_rdata, 0);
    tick();
    clear_inputs();
    tick();

    // ---------------- starvation: D continuous, I held ----------------
    d_read = 1; i_read = 1; d_addr = 28'h100; i_addr = 28'h200;
    seq_exp = "DDDDIDDDDI";
    seq_got = "";
    for (int t = 0; t < 10; t++) begin
      tick();
      seq_got = {seq_got, grant_d ? "D" : (grant_i ? "I" : "-")};
      mem_ready = 1;
      tick();
      mem_ready = 0;
    end
    checks++;
    if (seq_got != seq_exp) begin
      errors++;
      $display("FAIL starvation_order: got %s expected %s", seq_got, seq_exp);
    end
    clear_inputs();
    tick();

    // ---------------- read+write together, inputs changed while busy ----------------
    d_read = 1; d_write = 1; d_addr = 28'h77; d_wdata = 128'hAAAA;
    tick();
    check("rw_cmd", {mem_read, mem_write}, 2'b01);
    d_addr = 28'h99; d_wdata = 128'hBBBB; d_write = 0;
    tick();
    check("hold_addr", mem_addr, 28'h77);
    check("hold_wdata", mem_wdata, 128'hAAAA);
    check("hold_cmd", {mem_read, mem_write}, 2'b01);
    mem_ready = 1;
    tick();
    clear_inputs();
    tick();

    // ---------------- spurious mem_ready in IDLE ----------------
    for (int s = 0; s < 2; s++) begin
      mem_ready = 1; mem_rdata = 128'hDEAD;
      #1;
      check($sformatf("spurious%0d_ready", s), {d_ready, i_ready}, 0);
      check($sformatf("spurious%0d_rdata", s), d_rdata | i_rdata, 0);
      tick();
      check($sformatf("spurious%0d_idle", s), {grant_d, grant_i, mem_read, mem_write}, 0);
    end
    clear_inputs();
    tick();

    // ---------------- reset in the middle of a D write ----------------
    d_write = 1; d_addr = 28'h55; d_wdata = 128'h5555;
    tick();
    check("rstmid_busy", mem_write, 1);
    #2;
    rst = 0;
    #1;
    check_all_zero("rstmid");
    tick();
    rst = 1;
    clear_inputs();
    mem_ready = 1;
    #1;
    check("rstmid_no_ready", {d_ready, i_ready}, 0);
    tick();
    check("rstmid_idle", {grant_d, grant_i, mem_write}, 0);
    clear_inputs();

    // ---------------- randomized run against a transaction model ----------------
    do_reset();
    owner = 0; streak_m = 0; lat = 0;
    exp_wr = 0; exp_addr = '0; exp_wd = '0;
    p_dr = 0; p_dw = 0; p_ir = 0; p_ready = 0; p_dready = 0; p_iready = 0;
    p_da = '0; p_ia = '0; p_wd = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      tick();
      // Transaction-level update for the edge just taken.
      if (owner != 0) begin
        if (p_ready) owner = 0;
      end else if ((p_dr || p_dw) || p_ir) begin
        if ((p_dr || p_dw) && !(p_ir && streak_m == MAX)) begin
          owner = 1; exp_addr = p_da; exp_wd = p_wd; exp_wr = p_dw;
          streak_m = p_ir ? ((streak_m + 1 > MAX) ? MAX : streak_m + 1) : 0;
        end else begin
          owner = 2; exp_addr = p_ia; exp_wr = 0; streak_m = 0;
        end
        lat = $urandom_range(0, 4);
      end
      check("rnd_grant", {grant_d, grant_i}, {owner == 1, owner == 2});
      check("rnd_cmd", {mem_read, mem_write}, {owner != 0 && !exp_wr, owner != 0 && exp_wr});
      if (owner != 0) check("rnd_addr", mem_addr, exp_addr);
      if (owner == 1 && exp_wr) check("rnd_wdata", mem_wdata, exp_wd);

      // Requesters: drop after own ready, otherwise hold; idle ones may start.
      if (p_dready) begin d_read = 0; d_write = 0; end
      if (p_iready) i_read = 0;
      if (!(d_read || d_write) && $urandom_range(0, 1) == 1) begin
        d_read = $urandom_range(0, 1); d_write = !d_read || ($urandom_range(0, 3) == 0);
        d_addr = AW'($urandom_range(0, 15));
        d_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!i_read && $urandom_range(0, 1) == 1) begin
        i_read = 1; i_addr = AW'($urandom_range(0, 15));
      end

      // Memory: respond after the chosen latency; occasional spurious ready.
      rd_val = '0;
      if (owner != 0) begin
        if (lat == 0) begin
          mem_ready = 1;
          if (exp_wr) begin
            mem_m[exp_addr] = exp_wd;
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
          end else begin
            rd_val = mem_m.exists(exp_addr) ? mem_m[exp_addr] : {100'd0, exp_addr};
            mem_rdata = rd_val;
          end
        end else begin
          lat--;
          mem_ready = 0;
          mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        end
      end else begin
        mem_ready = ($urandom_range(0, 7) == 0);
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
      #1;
      check("rnd_d_ready", d_ready, owner == 1 && mem_ready);
      check("rnd_i_ready", i_ready, owner == 2 && mem_ready);
      check("rnd_d_rdata", d_rdata, (owner == 1 && mem_ready) ? mem_rdata : '0);
      check("rnd_i_rdata", i_rdata, (owner == 2 && mem_ready) ? rd_val : '0);

      p_dr = d_read; p_dw = d_write; p_ir = i_read;
      p_da = d_addr; p_ia = i_addr; p_wd = d_wdata; p_ready = mem_ready;
      p_dready = (owner == 1) && mem_ready;
      p_iready = (owner == 2) && mem_ready;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
